// File: rtl/hemaia_clock_divider_ctrl.sv
// hemaia_clock_divider_ctrl
//
// Initiator-side sequencer for the hemaia clock divider's divisor programming
// interface. It takes one divisor-change request at a time, pulses it to the
// divider, and holds the divisor bus stable until the divider is guaranteed to
// have sampled it. It then reports completion and mirrors the divider's
// active divisor and gated state for CSR readback. It runs in the divider's
// input clock domain.
//
// Request handshake: a request transfers on any rising clk_i edge where
// req_valid_i && req_ready_o. req_ready_o is high only while idle. A request
// presented while the controller is busy is neither accepted nor queued, so
// the requester keeps req_valid_i high until it is accepted.
//
// Ports:
//   clk_i            divider input clock
//   rst_ni           asynchronous active-low reset (shared with the divider)
//   req_valid_i      change request valid
//   req_ready_o      controller can accept a request (idle)
//   req_divisor_i    requested divisor: 0 = gate, 1 = bypass, N = divide by N
//   busy_o           change sequence in progress (ISSUE/WAIT)
//   done_o           one-cycle completion pulse
//   cur_divisor_o    divisor currently applied by the divider (never 0)
//   gated_o          divider output currently gated
//   divisor_o        to divider divisor_i
//   divisor_valid_o  to divider divisor_valid_i, single-cycle pulse
//   state_o          current FSM state (debug)
module hemaia_clock_divider_ctrl #(
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned SettleCycles     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [MaxDivisionWidth-1:0] req_divisor_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [MaxDivisionWidth-1:0] cur_divisor_o,
  output logic                        gated_o,
  output logic [MaxDivisionWidth-1:0] divisor_o,
  output logic                        divisor_valid_o,
  output logic [1:0]                  state_o
);

  localparam int W  = MaxDivisionWidth;
  // Two extra bits hold 2*(2**W-1) + 2**W without overflow.
  localparam int CW = MaxDivisionWidth + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   target_q;
  logic [W-1:0]   divisor_q;
  logic [W-1:0]   cur_q;
  logic           gated_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  settle_load;
  logic           handshake;
  logic           noop;
  logic           wait_last;

  assign handshake = req_valid_i && (state_q == IDLE);
  // Re-requesting the active divisor of a running clock needs no divider access.
  assign noop      = (req_divisor_i == cur_q) && !gated_q && (req_divisor_i != '0);
  // The divider may need up to one full old period to reach its wrap and a
  // second one to settle on the new ratio; SettleCycles adds margin on top.
  assign settle_load = {1'b0, cur_q, 1'b0} + CW'(SettleCycles);
  assign wait_last   = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = noop ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      target_q  <= W'(DefaultDivision);
      divisor_q <= W'(DefaultDivision);
      cur_q     <= W'(DefaultDivision);
      gated_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (handshake) target_q <= req_divisor_i;
        end
        ISSUE: begin
          divisor_q <= target_q;
          cnt_q     <= settle_load;
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (wait_last) begin
            // Gating leaves the last running divisor as the readback value.
            if (target_q != '0) begin
              cur_q   <= target_q;
              gated_q <= 1'b0;
            end else begin
              gated_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The new divisor is presented together with the valid pulse, and the held
  // register takes over from the next cycle, so the bus only moves in ISSUE.
  assign divisor_o       = (state_q == ISSUE) ? target_q : divisor_q;
  assign divisor_valid_o = (state_q == ISSUE);
  assign req_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q == ISSUE) || (state_q == WAIT);
  assign done_o          = (state_q == DONE);
  assign cur_divisor_o   = cur_q;
  assign gated_o         = gated_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_hemaia_clock_divider_ctrl.sv
// Testbench for hemaia_clock_divider_ctrl: directed table, hand-written
// corner sequences, and randomized requests checked against a reference model.
// A small behavioural divider is attached to observe the resulting clock.
module tb_hemaia_clock_divider_ctrl;

  localparam int W   = 4;
  localparam int DEF = 1;
  localparam int SET = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] cur_divisor;
  logic         gated;
  logic [W-1:0] divisor;
  logic         divisor_valid;
  logic [1:0]   state_dbg;

  int tests = 0;
  int fails = 0;

  // Reference model of the mirrors and the idle divisor bus.
  int m_cur   = DEF;
  int m_gated = 0;
  int m_div   = DEF;

  always #5 clk = ~clk;

  hemaia_clock_divider_ctrl #(
    .MaxDivisionWidth(W),
    .DefaultDivision (DEF),
    .SettleCycles    (SET)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_divisor_i  (req_divisor),
    .busy_o         (busy),
    .done_o         (done),
    .cur_divisor_o  (cur_divisor),
    .gated_o        (gated),
    .divisor_o      (divisor),
    .divisor_valid_o(divisor_valid),
    .state_o        (state_dbg)
  );

  // Behavioural divider: samples divisor_o at its first wrap after a pulse.
  logic [W-1:0] div_act;
  logic [W-1:0] dcnt;
  logic         pend;
  logic         tick;
  assign tick = (div_act != '0) && (dcnt == div_act - 1'b1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act <= W'(DEF);
      dcnt    <= '0;
      pend    <= 1'b0;
    end else begin
      if (div_act == '0 || tick) begin
        dcnt <= '0;
        if (pend) begin
          div_act <= divisor;
          pend    <= 1'b0;
        end
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      if (divisor_valid) pend <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input int d);
    if (d == m_cur && m_gated == 0 && d != 0) return 1;
    return 2 + 2 * m_cur + SET;
  endfunction

  function automatic int exp_pulses(input int d);
    return (d == m_cur && m_gated == 0 && d != 0) ? 0 : 1;
  endfunction

  task automatic model_apply(input int d);
    if (!(d == m_cur && m_gated == 0 && d != 0)) begin
      m_div = d;
      if (d != 0) begin
        m_cur   = d;
        m_gated = 0;
      end else begin
        m_gated = 1;
      end
    end
  endtask

  // Called at a negedge with the controller idle; returns at the negedge where
  // done_o is observed. lat counts cycles from the handshake edge.
  task automatic do_req(input logic [W-1:0] d, output int lat, output int pulses,
                        output int pdiv, output int busy_seen);
    req_valid   = 1'b1;
    req_divisor = d;
    pulses = 0; pdiv = -1; busy_seen = 0; lat = 0;
    check("ready_before_req", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (lat < 200) begin
      if (divisor_valid) begin
        pulses++;
        pdiv = int'(divisor);
      end
      if (busy) busy_seen = 1;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("done_timeout", lat, 0);
  endtask

  task automatic run_and_check(input string tag, input int d);
    int lat, pulses, pdiv, bs, el, ep;
    el = exp_latency(d);
    ep = exp_pulses(d);
    do_req(W'(d), lat, pulses, pdiv, bs);
    model_apply(d);
    check({tag, "_latency"}, lat, el);
    check({tag, "_pulses"}, pulses, ep);
    if (ep == 1) check({tag, "_pulse_divisor"}, pdiv, d);
    check({tag, "_busy_seen"}, bs, ep);
    check({tag, "_cur"}, int'(cur_divisor), m_cur);
    check({tag, "_gated"}, int'(gated), m_gated);
    @(negedge clk);
    check({tag, "_idle_divisor"}, int'(divisor), m_div);
    check({tag, "_idle_ready"}, int'(req_ready), 1);
  endtask

  // Period between two divided-clock ticks, or 0 if none appear in the window.
  task automatic measure_period(output int per);
    int t0;
    per = 0; t0 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tick) begin
        if (t0 >= 0) begin
          per = i - t0;
          break;
        end
        t0 = i;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, int'(req_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_valid"}, int'(divisor_valid), 0);
    check({tag, "_divisor"}, int'(divisor), DEF);
    check({tag, "_cur"}, int'(cur_divisor), DEF);
    check({tag, "_gated"}, int'(gated), 0);
  endtask

  typedef struct {
    logic [W-1:0] div;
    int           lat;
    int           cur;
    int           gated;
    int           pulses;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, pulses, pdiv, bs, per, nticks, ready_leak;
    vecs[0] = '{4'd4,  8, 4,  0, 1};
    vecs[1] = '{4'd0, 14, 4,  1, 1};
    vecs[2] = '{4'd4, 14, 4,  0, 1};
    vecs[3] = '{4'd5, 14, 5,  0, 1};
    vecs[4] = '{4'd5,  1, 5,  0, 0};
    vecs[5] = '{4'd15, 16, 15, 0, 1};
    vecs[6] = '{4'd3, 36, 3,  0, 1};
    vecs[7] = '{4'd0, 12, 3,  1, 1};
    vecs[8] = '{4'd0, 12, 3,  1, 1};
    vecs[9] = '{4'd1, 12, 1,  0, 1};

    // Reset state, including no stray pulse while held in reset.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_valid", int'(divisor_valid), 0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].div, lat, pulses, pdiv, bs);
      model_apply(int'(vecs[i].div));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_pulses", i), pulses, vecs[i].pulses);
      if (vecs[i].pulses == 1) check($sformatf("vec%0d_pdiv", i), pdiv, int'(vecs[i].div));
      check($sformatf("vec%0d_busy", i), bs, vecs[i].pulses);
      check($sformatf("vec%0d_cur", i), int'(cur_divisor), vecs[i].cur);
      check($sformatf("vec%0d_gated", i), int'(gated), vecs[i].gated);
      @(negedge clk);
      if (i == 0 || i == 2) begin
        measure_period(per);
        check($sformatf("vec%0d_div_period", i), per, 4);
      end
      if (i == 1) begin
        nticks = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (tick) nticks++;
        end
        check("gated_ticks", nticks, 0);
      end
    end

    // Held valid through a long change with the value changed mid-WAIT.
    run_and_check("to15", 15);
    req_valid   = 1'b1;
    req_divisor = 4'd3;
    ready_leak  = 0;
    lat         = 0;
    @(negedge clk);
    lat = 1;
    while (lat < 200 && !done) begin
      if (req_ready) ready_leak++;
      if (lat == 5) req_divisor = 4'd7;
      @(negedge clk);
      lat++;
    end
    check("hold_latency", lat, 36);
    check("hold_ready_leak", ready_leak, 0);
    check("hold_cur", int'(cur_divisor), 3);
    m_cur = 3; m_div = 3;
    @(negedge clk);
    check("hold_idle_ready", int'(req_ready), 1);
    check("hold_idle_busy", int'(busy), 0);
    @(negedge clk);
    check("hold_second_pulse", int'(divisor_valid), 1);
    check("hold_second_divisor", int'(divisor), 7);
    req_valid = 1'b0;
    lat = 0;
    while (lat < 200 && !done) begin
      @(negedge clk);
      lat++;
    end
    check("hold_second_cur", int'(cur_divisor), 7);
    m_cur = 7; m_div = 7;
    @(negedge clk);

    // Asynchronous reset in the middle of WAIT of a 1->7 change.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = DEF; m_gated = 0; m_div = DEF;
    @(negedge clk);
    req_valid   = 1'b1;
    req_divisor = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midwait_busy", int'(busy), 1);
    check("midwait_divisor", int'(divisor), 7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_and_check("after_reset", 7);

    // Randomized requests against the model.
    for (int t = 0; t < 40; t++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? m_cur : int'($urandom_range(0, 15));
      run_and_check($sformatf("rnd%0d", t), d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hemaia_clock_divider_ctrl.md
Name: hemaia_clock_divider_ctrl

Overview:
Initiator-side sequencer for the hemaia clock divider's divisor programming interface (divisor + single-cycle valid).
- Accepts divisor-change requests over a valid/ready handshake.
- Drives the divider's divisor bus and valid pulse, and holds the divisor stable until the divider has applied it.
- Signals completion and mirrors the divider's active divisor and gated state for CSR readback.
- Sits in the clock/reset controller next to each divider instance, in the divider's input clock domain.

Parameters:
MaxDivisionWidth, 4, width of the divisor bus; must match the driven divider.
DefaultDivision, 1, divider's reset divisor; mirrored at reset; must be 1..2**MaxDivisionWidth-1 (0 illegal).
SettleCycles, 4, extra margin cycles added to the settle wait; range 0..2**MaxDivisionWidth.

Ports:
clk_i  input  1  divider input clock (same clock as the divider's clk_i)
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  change request valid
req_ready_o  output  1  controller can accept a request
req_divisor_i  input  MaxDivisionWidth  requested divisor; 0 = gate clock, 1 = bypass, N = divide by N
busy_o  output  1  change sequence in progress
done_o  output  1  one-cycle pulse, sequence complete
cur_divisor_o  output  MaxDivisionWidth  divisor currently applied by the divider (never 0)
gated_o  output  1  divider output currently gated
divisor_o  output  MaxDivisionWidth  to divider divisor_i
divisor_valid_o  output  1  to divider divisor_valid_i; single-cycle pulse

Behaviour:
- Reset values: req_ready_o=1 (combinational from IDLE), busy_o=0, done_o=0, divisor_valid_o=0, divisor_o=DefaultDivision, cur_divisor_o=DefaultDivision, gated_o=0, FSM=IDLE, settle counter=0.
- FSM states: IDLE, ISSUE, WAIT, DONE. busy_o=1 in ISSUE and WAIT. req_ready_o=1 only in IDLE.
- IDLE:
  - A handshake occurs when req_valid_i && req_ready_o.
  - On handshake, latch req_divisor_i into target_q.
  - No-op case (req_divisor_i == cur_divisor_o, gated_o==0, req_divisor_i != 0): go directly to DONE. No valid pulse; divisor_o unchanged.
  - Otherwise: go to ISSUE.
- ISSUE, exactly 1 cycle:
  - divisor_valid_o=1 and divisor_o=target_q in the same cycle.
  - Load settle counter with 2*cur_divisor_o + SettleCycles, computed in MaxDivisionWidth+2 bits with no overflow.
  - Next state: WAIT.
- WAIT:
  - divisor_valid_o=0; divisor_o held at target_q, because the divider samples its divisor input only at its counter wrap after the pulse.
  - Counter decrements once per cycle.
  - In the cycle the counter reaches 0: go to DONE and update the mirrors. If target_q != 0: cur_divisor_o=target_q, gated_o=0. If target_q == 0: cur_divisor_o unchanged, gated_o=1.
- DONE, exactly 1 cycle: done_o=1; next state IDLE. The next request can handshake in the cycle after DONE.
- Latency from handshake to done_o:
  - No-op request: 1 cycle (done_o in the cycle after handshake).
  - Otherwise: 2 + 2*old_divisor + SettleCycles cycles.
- divisor_o changes only in ISSUE; it is stable at all other times. Idle value = last issued target, including 0 when gated.
- Ungating: a request with nonzero N while gated_o=1 always runs the full sequence, even when N == cur_divisor_o.
- Repeated gating: a request of 0 while already gated runs the full sequence; the mirrors are unchanged.
- req_valid_i while not in IDLE: ignored. No handshake, no queuing; the requester must hold valid.
- Async reset mid-sequence returns everything to reset values immediately. The divider shares rst_ni, so both ends are reset together.

Test Plan:
- Reset with DefaultDivision=1 -> cur_divisor_o=1, divisor_o=1, gated_o=0, req_ready_o=1, no pulse on divisor_valid_o.
- Request 4 from divisor 1, SettleCycles=4 -> exactly one divisor_valid_o pulse with divisor_o=4; done_o 8 cycles after handshake; cur_divisor_o=4; divider output period measured as 4 clk_i cycles after done_o.
- From divisor 4, request 0 -> done_o after 14 cycles; gated_o=1; cur_divisor_o=4; divider output flat. Then request 4 -> full sequence with pulse; gated_o=0; clock resumes at /4.
- From divisor 5, request 5 (not gated) -> no valid pulse; done_o 1 cycle after handshake; busy_o never asserted.
- From divisor 15, request 3, with req_valid_i held high through WAIT and a second value applied -> second request not accepted until the cycle after done_o; first change completes at 2+30+4=36 cycles.
- Assert rst_ni low during WAIT of a 1->7 change -> all outputs return to reset values asynchronously; after release, cur_divisor_o=DefaultDivision and a new request is accepted.
